// File: rtl/imem_slv.sv
// Instruction-memory responder: range-checks single-word fetches, forwards legal ones
// to a variable-latency backend and returns data with a 2-bit fault code.
`ifndef IM_ADDR_LEN
`define IM_ADDR_LEN 32
`endif
`ifndef IM_DATA_LEN
`define IM_DATA_LEN 32
`endif

module imem_slv #(
  parameter logic [`IM_ADDR_LEN-1:0] BASE_ADDR = '0,
  parameter logic [`IM_ADDR_LEN-1:0] SIZE      = `IM_ADDR_LEN'h10000,
  parameter int unsigned             TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    imem_req,
  input  logic [`IM_ADDR_LEN-1:0] imem_addr,
  output logic [`IM_DATA_LEN-1:0] imem_rdata,
  output logic [1:0]              imem_bad,
  output logic                    imem_busy,
  output logic                    mem_req,
  output logic [`IM_ADDR_LEN-1:0] mem_addr,
  input  logic                    mem_ack,
  input  logic [`IM_DATA_LEN-1:0] mem_rdata,
  input  logic                    mem_err
);

  localparam int unsigned AW = `IM_ADDR_LEN;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [AW-1:0] REGION_MASK = ~(SIZE - AW'(1));
  localparam logic [7:0]    CNT_LAST    = 8'(TIMEOUT - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] cnt, cnt_nxt, cnt_inc;

  logic accept, in_range;
  logic resp_ack, resp_to, resp_err, resp;

  assign in_range = (imem_addr & REGION_MASK) == BASE_ADDR;
  assign accept   = imem_req && !imem_busy;

  // Ack takes priority over a coincident timeout.
  assign resp_ack = (state == ST_WAIT) && mem_ack;
  assign resp_to  = (state == ST_WAIT) && !mem_ack && (cnt == CNT_LAST);
  assign resp_err = (state == ST_ERR);
  assign resp     = resp_ack || resp_to || resp_err;

  assign imem_busy  = ((state == ST_WAIT) && !resp) || (state == ST_DRAIN);
  assign imem_rdata = resp_ack ? mem_rdata : '0;

  always_comb begin
    imem_bad = 2'b00;
    if ((resp_ack && mem_err) || resp_to) imem_bad = 2'b01;
    else if (resp_err)                    imem_bad = 2'b10;
  end

  assign mem_req  = accept && in_range;
  assign mem_addr = mem_req ? {imem_addr[AW-1:2], 2'b00} : '0;

  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = in_range ? ST_WAIT : ST_ERR;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        // A response frees the port, so a new fetch may be taken in the same cycle.
        if (resp && accept) begin
          state_nxt = in_range ? ST_WAIT : ST_ERR;
          cnt_nxt   = '0;
        end else if (mem_ack) begin
          state_nxt = ST_IDLE;
        end else if (resp_to) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_ERR: begin
        if (accept) begin
          state_nxt = in_range ? ST_WAIT : ST_ERR;
          cnt_nxt   = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (mem_ack || (cnt == CNT_LAST)) state_nxt = ST_IDLE;
        else                              cnt_nxt   = cnt_inc;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: doc/imem_slv.md
Name: imem_slv

Overview:
Responder end of the instruction-memory interface driven by the prefetch unit. It accepts single-word fetch requests, checks them against the instruction region and forwards legal ones to a variable-latency backend memory port. It returns data with a 2-bit fault code, stalling the fetcher through imem_busy. The block sits between the CPU fetch port and the instruction SRAM/bus bridge.

Parameters:
BASE_ADDR, `IM_ADDR_LEN'h0, first byte address of the legal instruction region; aligned to SIZE
SIZE, `IM_ADDR_LEN'h10000, region size in bytes; power of two
TIMEOUT, 64, cycles to wait for mem_ack before declaring a bus error; 2..255

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
imem_req  in  1  fetch request; accepted when imem_req && ~imem_busy
imem_addr  in  `IM_ADDR_LEN  fetch byte address; bits [1:0] are ignored and treated as 0
imem_rdata  out  `IM_DATA_LEN  fetch data; valid in the response cycle
imem_bad  out  2  fault code, valid with imem_rdata: 00 ok, 01 bus error, 10 access fault
imem_busy  out  1  response not ready / new request not accepted
mem_req  out  1  backend request, single-cycle pulse
mem_addr  out  `IM_ADDR_LEN  backend word address, {imem_addr[hi:2],2'b0}
mem_ack  in  1  backend completion; never in the same cycle as its mem_req
mem_rdata  in  `IM_DATA_LEN  backend data, valid with mem_ack
mem_err  in  1  backend error, valid with mem_ack

Behaviour:
- Reset values: state IDLE, imem_busy 0, imem_rdata 0, imem_bad 00, mem_req 0, timeout counter 0. Reset mid-transaction abandons it; a mem_ack after reset is ignored.
- States are IDLE, WAIT, ERR and DRAIN.
- accept = imem_req && ~imem_busy. in_range = (imem_addr & ~(SIZE-1)) == BASE_ADDR.
- mem_req = accept && in_range. It is combinational in the accept cycle. mem_addr is combinational from imem_addr and is 0 when mem_req is low.
- A response cycle occurs in any of these cases:
  - WAIT && mem_ack
  - WAIT && cnt==TIMEOUT-1
  - state ERR
- Outputs in a response cycle:
  - imem_busy = 0.
  - imem_rdata = mem_rdata on ack, else 0.
  - imem_bad = 01 when (ack && mem_err) or on timeout; 10 in ERR; 00 otherwise.
- Outside a response cycle, imem_rdata = 0 and imem_bad = 00.
- imem_busy by state:
  - IDLE: 0.
  - WAIT: 1 except in a response cycle.
  - ERR: 0.
  - DRAIN: 1.
- Transitions. Each state is checked in the order listed; the first matching rule applies.
  - IDLE: accept && in_range -> WAIT. accept && ~in_range -> ERR.
  - WAIT: a response cycle with a new accept -> WAIT or ERR per in_range, with the counter cleared. Ack without a new accept -> IDLE. Timeout without a new accept -> DRAIN, because the late ack must be swallowed.
  - ERR: lasts exactly one cycle. A new accept in that cycle -> WAIT or ERR. Otherwise -> IDLE.
  - DRAIN: mem_ack -> IDLE, discarding data and err. cnt==TIMEOUT-1 -> IDLE. No request is accepted while in DRAIN.
  - Simultaneous ack and timeout: the ack wins. Data is returned with the code from mem_err.
  - Timeout taken in the same cycle as a new accept: the abandoned transaction is not drained. The backend must not ack it afterwards; TIMEOUT is sized accordingly.
- Timeout counter: 8 bits. Cleared on entry to WAIT or DRAIN. Increments each cycle in WAIT or DRAIN and saturates.
- Latency:
  - Zero-wait backend (ack one cycle after mem_req): one word per cycle back-to-back, with imem_busy never asserted.
  - Each backend wait cycle adds one cycle of imem_busy=1.
- At most one backend transaction is outstanding at any time.

Test Plan:
- Zero-wait stream: req every cycle at addr 0x0,0x4,0x8,0xC, ack next cycle with rdata 0x11111111..0x44444444. Required: busy stays 0, four responses in consecutive cycles, bad=00, mem_addr matches.
- Wait states: req at 0x20, ack after 3 cycles with 0xDEADBEEF. Required: busy=1 for 2 cycles, then busy=0 with rdata 0xDEADBEEF, bad=00, state back to IDLE.
- Backend error: ack with mem_err=1, rdata 0x12345678. Required: rdata 0x12345678, bad=01 in the response cycle.
- Out of range: with BASE_ADDR=0, SIZE=0x10000, req 0x10004 then 0x8 on the next cycle. Required: no mem_req for the first; ERR response of rdata 0, bad=10, busy=0; second request accepted in the same cycle with mem_req=1, addr 0x8.
- Timeout: TIMEOUT=4, no ack. Required: busy=1 for 3 cycles, then a response with bad=01 and rdata 0. DRAIN holds busy=1 until the late ack at cycle 6, whose data is discarded, then IDLE accepts a new req.
- Reset mid-WAIT: assert rstn=0 two cycles after the request. Required: busy=0, rdata=0, bad=00 immediately. The subsequent mem_ack produces no response.
